// File: rtl/tt_ajah_stott_holmes_serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_ajah_stott_holmes_serial_subtractor_if
// Brief    : Tiny Tapeout user pin bundle for the bit-serial subtractor tile.
// Revision : 1.0
// ============================================================================
interface tt_ajah_stott_holmes_serial_subtractor_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface
`default_nettype wire

// File: rtl/tt_ajah_stott_holmes_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tt_ajah_stott_holmes_serial_subtractor
// Brief    : LSB-first serial A-B (8-bit words, registered borrow);
//            `SERIAL_SUB_SATURATE_EN clamps borrowing results to 0x00.
// Revision : 1.0
// ============================================================================
module tt_ajah_stott_holmes_serial_subtractor (
  input  logic clk,
  input  logic rst_n,
  tt_ajah_stott_holmes_serial_subtractor_if.slave io
);

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       brw_q, brw_d;
  logic [7:0] work_q, work_d;
  logic [7:0] result_q, result_d;
  logic       diff_bit_q, diff_bit_d;
  logic       borrow_q, borrow_d;
  logic       done_q, done_d;

  logic       a_bit, b_bit, valid_eff, bit_last;
  logic       d_bit, brw_next, end_of_word;
  logic [7:0] keep_mask, word_final;

  assign a_bit       = io.ui_in[0];
  assign b_bit       = io.ui_in[1];
  assign valid_eff   = io.ui_in[2] & io.ena;
  assign bit_last    = io.ui_in[3];

  assign d_bit       = a_bit ^ b_bit ^ brw_q;
  assign brw_next    = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_q);
  assign end_of_word = valid_eff & (bit_last | (bit_cnt_q == 3'd7));

  // Bits 0..bit_cnt kept, current bit spliced in, higher bits zero-extended.
  assign keep_mask   = 8'hFF >> (3'd7 - bit_cnt_q);
  assign word_final  = ((work_q & ~(8'd1 << bit_cnt_q)) | ({7'd0, d_bit} << bit_cnt_q))
                       & keep_mask;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    brw_d      = brw_q;
    work_d     = work_q;
    result_d   = result_q;
    diff_bit_d = diff_bit_q;
    borrow_d   = borrow_q;
    done_d     = 1'b0;

    if (valid_eff) begin
      diff_bit_d         = d_bit;
      work_d[bit_cnt_q]  = d_bit;
      if (end_of_word) begin
`ifdef SERIAL_SUB_SATURATE_EN
        result_d = brw_next ? 8'h00 : word_final;
`else
        result_d = word_final;
`endif
        borrow_d  = brw_next;
        done_d    = 1'b1;
        bit_cnt_d = 3'd0;
        brw_d     = 1'b0;
        work_d    = 8'd0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        brw_d     = brw_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt_q  <= 3'd0;
      brw_q      <= 1'b0;
      work_q     <= 8'd0;
      result_q   <= 8'd0;
      diff_bit_q <= 1'b0;
      borrow_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      brw_q      <= brw_d;
      work_q     <= work_d;
      result_q   <= result_d;
      diff_bit_q <= diff_bit_d;
      borrow_q   <= borrow_d;
      done_q     <= done_d;
    end
  end

  assign io.uo_out  = result_q;
  assign io.uio_out = {1'b0, bit_cnt_q, (bit_cnt_q != 3'd0), done_q, borrow_q, diff_bit_q};
  assign io.uio_oe  = 8'hFF;

  logic unused_ok;
  assign unused_ok = &{1'b0, io.ui_in[7:4], io.uio_in};

endmodule
`default_nettype wire
